// File: rtl/regfile_wb_arbiter.sv
// Write-side front end for the 16x32b dual-write-port register file: two buffered
// writeback channels feed write ports 1/2, never issuing the same address on both ports in one cycle.

module regfile_wb_fifo #(
    parameter int AW    = 4,
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][AW+DW-1:0] mem;
    logic [PW-1:0]               wr_ptr, rd_ptr;

    assign {head_addr, head_data} = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {push_addr, push_data};
    end
endmodule

module regfile_wb_arbiter #(
    parameter int AW    = 4,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in0_valid,
    output logic          in0_ready,
    input  logic [AW-1:0] in0_addr,
    input  logic [DW-1:0] in0_data,
    input  logic          in1_valid,
    output logic          in1_ready,
    input  logic [AW-1:0] in1_addr,
    input  logic [DW-1:0] in1_data,
    output logic          wr1_wren,
    output logic [AW-1:0] wr1_addr,
    output logic [DW-1:0] wr1_data,
    output logic          wr2_wren,
    output logic [AW-1:0] wr2_addr,
    output logic [DW-1:0] wr2_data,
    output logic          idle,
    output logic [15:0]   collision_cnt
);
    localparam int NCH = 2;
    localparam int CW  = $clog2(DEPTH) + 1;

    logic [NCH-1:0]         in_valid, in_ready, push, issue, nonempty, empty_after;
    logic [NCH-1:0][AW-1:0] in_addr, head_addr;
    logic [NCH-1:0][DW-1:0] in_data, head_data;
    logic [NCH-1:0][CW-1:0] count;
    logic                   rr, collide;

    assign in_valid  = {in1_valid, in0_valid};
    assign in_addr   = {in1_addr, in0_addr};
    assign in_data   = {in1_data, in0_data};
    assign in0_ready = in_ready[0];
    assign in1_ready = in_ready[1];

    genvar ch;
    generate
        for (ch = 0; ch < NCH; ch++) begin : g_ch
            // No pass-through: a full FIFO refuses even when it pops this cycle.
            assign in_ready[ch]    = !rst && (count[ch] != CW'(DEPTH));
            assign push[ch]        = in_valid[ch] && in_ready[ch];
            assign nonempty[ch]    = (count[ch] != '0);
            assign empty_after[ch] = !push[ch] && (count[ch] == CW'(issue[ch]));

            regfile_wb_fifo #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .push      (push[ch]),
                .pop       (issue[ch]),
                .push_addr (in_addr[ch]),
                .push_data (in_data[ch]),
                .head_addr (head_addr[ch]),
                .head_data (head_data[ch]),
                .count     (count[ch])
            );
        end
    endgenerate

    // Same-address heads: rr picks the winner; the loser retries next cycle so it lands last.
    always_comb begin
        collide = (&nonempty) && (head_addr[0] == head_addr[1]);
        issue   = nonempty;
        if (collide) issue = rr ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr1_wren      <= 1'b0;
            wr1_addr      <= '0;
            wr1_data      <= '0;
            wr2_wren      <= 1'b0;
            wr2_addr      <= '0;
            wr2_data      <= '0;
            rr            <= 1'b0;
            collision_cnt <= '0;
            idle          <= 1'b1;
        end else begin
            wr1_wren <= issue[0];
            wr2_wren <= issue[1];
            if (issue[0]) begin
                wr1_addr <= head_addr[0];
                wr1_data <= head_data[0];
            end
            if (issue[1]) begin
                wr2_addr <= head_addr[1];
                wr2_data <= head_data[1];
            end
            if (collide) begin
                rr <= ~rr;
                if (collision_cnt != 16'hFFFF) collision_cnt <= collision_cnt + 16'd1;
            end
            idle <= (&empty_after) && (issue == '0);
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized + directed bench for regfile_wb_arbiter against a queue-based reference model.

module tb_regfile_wb_arbiter;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in0_valid, in1_valid;
    logic          in0_ready, in1_ready;
    logic [AW-1:0] in0_addr, in1_addr;
    logic [DW-1:0] in0_data, in1_data;
    logic          wr1_wren, wr2_wren;
    logic [AW-1:0] wr1_addr, wr2_addr;
    logic [DW-1:0] wr1_data, wr2_data;
    logic          idle;
    logic [15:0]   collision_cnt;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .in0_valid     (in0_valid),
        .in0_ready     (in0_ready),
        .in0_addr      (in0_addr),
        .in0_data      (in0_data),
        .in1_valid     (in1_valid),
        .in1_ready     (in1_ready),
        .in1_addr      (in1_addr),
        .in1_data      (in1_data),
        .wr1_wren      (wr1_wren),
        .wr1_addr      (wr1_addr),
        .wr1_data      (wr1_data),
        .wr2_wren      (wr2_wren),
        .wr2_addr      (wr2_addr),
        .wr2_data      (wr2_data),
        .idle          (idle),
        .collision_cnt (collision_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: per-channel queues of {addr,data}, expected registered outputs.
    logic [AW+DW-1:0] q0[$], q1[$];
    logic             m_rr;
    int               m_cnt;
    logic             e1_wren, e2_wren, e_idle, r0, r1;
    logic [AW-1:0]    e1_addr, e2_addr;
    logic [DW-1:0]    e1_data, e2_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Called near the negedge with inputs already driven; advances one clock.
    task automatic cycle();
        logic iss0, iss1, ne0, ne1;
        logic [AW+DW-1:0] h;
        #1;
        r0 = !rst && (q0.size() != DEPTH);
        r1 = !rst && (q1.size() != DEPTH);
        check("in0_ready", 64'(in0_ready), 64'(r0));
        check("in1_ready", 64'(in1_ready), 64'(r1));
        if (rst) begin
            q0.delete(); q1.delete();
            m_rr = 1'b0; m_cnt = 0; e_idle = 1'b1;
            e1_wren = 1'b0; e1_addr = '0; e1_data = '0;
            e2_wren = 1'b0; e2_addr = '0; e2_data = '0;
        end else begin
            ne0 = q0.size() > 0;
            ne1 = q1.size() > 0;
            iss0 = ne0;
            iss1 = ne1;
            if (ne0 && ne1 && q0[0][AW+DW-1:DW] == q1[0][AW+DW-1:DW]) begin
                if (m_rr) iss0 = 1'b0; else iss1 = 1'b0;
                m_rr = ~m_rr;
                if (m_cnt < 65535) m_cnt++;
            end
            e1_wren = iss0;
            e2_wren = iss1;
            if (iss0) begin h = q0.pop_front(); {e1_addr, e1_data} = h; end
            if (iss1) begin h = q1.pop_front(); {e2_addr, e2_data} = h; end
            if (in0_valid && r0) q0.push_back({in0_addr, in0_data});
            if (in1_valid && r1) q1.push_back({in1_addr, in1_data});
            e_idle = (q0.size() == 0) && (q1.size() == 0) && !iss0 && !iss1;
        end
        @(posedge clk);
        #1;
        check("wr1_wren", 64'(wr1_wren), 64'(e1_wren));
        check("wr1_addr", 64'(wr1_addr), 64'(e1_addr));
        check("wr1_data", 64'(wr1_data), 64'(e1_data));
        check("wr2_wren", 64'(wr2_wren), 64'(e2_wren));
        check("wr2_addr", 64'(wr2_addr), 64'(e2_addr));
        check("wr2_data", 64'(wr2_data), 64'(e2_data));
        check("idle", 64'(idle), 64'(e_idle));
        check("collision_cnt", 64'(collision_cnt), 64'(m_cnt));
        check("no_same_addr", 64'(wr1_wren && wr2_wren && wr1_addr == wr2_addr), 64'(0));
        @(negedge clk);
    endtask

    task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        in0_valid = v0; in0_addr = a0; in0_data = d0;
        in1_valid = v1; in1_addr = a1; in1_data = d1;
    endtask

    initial begin
        int k;
        logic [DW-1:0] stream [6];
        rst = 1'b1;
        drive(0, '0, '0, 0, '0, '0);
        @(negedge clk);
        cycle(); cycle();
        rst = 1'b0;
        check("reset_idle", 64'(idle), 64'(1));

        // Single write latency: accept at edge 1, wren visible only after edge 2.
        drive(1, 4'd3, 32'hA5A5A5A5, 0, '0, '0);
        cycle();
        check("lat_e1_wren", 64'(wr1_wren), 64'(0));
        check("lat_e1_idle", 64'(idle), 64'(0));
        drive(0, '0, '0, 0, '0, '0);
        cycle();
        check("lat_e2_wren", 64'(wr1_wren), 64'(1));
        check("lat_e2_data", 64'(wr1_data), 64'(32'hA5A5A5A5));
        cycle();
        check("lat_e3_wren", 64'(wr1_wren), 64'(0));
        check("lat_e3_idle", 64'(idle), 64'(1));

        // Distinct addresses issue together.
        drive(1, 4'd5, 32'h11, 1, 4'd9, 32'h22);
        cycle();
        drive(0, '0, '0, 0, '0, '0);
        cycle();
        check("dual_both", 64'(wr1_wren && wr2_wren), 64'(1));
        cycle();

        // Two collisions on address 7: winner alternates.
        repeat (2) begin
            drive(1, 4'd7, 32'hAAAA, 1, 4'd7, 32'hBBBB);
            cycle();
            drive(0, '0, '0, 0, '0, '0);
            repeat (3) cycle();
        end
        check("coll_cnt2", 64'(collision_cnt), 64'(2));

        // Six back-to-back entries on channel 0.
        for (int i = 0; i < 6; i++) stream[i] = $urandom;
        k = 0;
        for (int t = 0; t < 50 && k < 6; t++) begin
            drive(1, 4'(k), stream[k], 0, '0, '0);
            cycle();
            if (r0) k++;
        end
        check("b2b_all_sent", 64'(k), 64'(6));
        drive(0, '0, '0, 0, '0, '0);
        repeat (3) cycle();

        // Fill both FIFOs with same-address traffic, then reset mid-flight.
        for (int t = 0; t < 8; t++) begin
            drive(1, 4'd2, $urandom, 1, 4'd2, $urandom);
            cycle();
        end
        drive(0, '0, '0, 0, '0, '0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_idle", 64'(idle), 64'(1));
        check("rst_cnt", 64'(collision_cnt), 64'(0));
        repeat (4) cycle();
        check("rst_no_issue", 64'(wr1_wren || wr2_wren), 64'(0));

        // Randomized traffic with a narrow address range and occasional reset.
        for (int t = 0; t < 3000; t++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), $urandom,
                  $urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), $urandom);
            cycle();
        end
        rst = 1'b0;

        // Saturate the collision counter.
        for (int t = 0; t < 65600; t++) begin
            drive(1, 4'd6, $urandom, 1, 4'd6, $urandom);
            cycle();
        end
        check("coll_sat", 64'(collision_cnt), 64'(16'hFFFF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
